// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down modulo counter with wrap-around, range-checked
// load and a combinational carry for chaining stages.
module bcd_mod_counter #(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ena,
    input  logic       i_inc,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic [7:0] o_q,
    output logic       o_carry,
    output logic       o_roll,
    output logic       o_load_err
);

    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 99) begin : g_bad_range
        $fatal(1, "bcd_mod_counter: need 0 <= MIN_VAL < MAX_VAL <= 99");
    end

    localparam logic [7:0] MIN_BCD = {4'(MIN_VAL / 10), 4'(MIN_VAL % 10)};
    localparam logic [7:0] MAX_BCD = {4'(MAX_VAL / 10), 4'(MAX_VAL % 10)};

    logic [3:0] tens;
    logic [3:0] units;
    logic       at_max;
    logic       at_min;
    logic       wrap;
    logic [7:0] q_step;
    logic [8:0] lo_diff;
    logic [8:0] hi_diff;
    logic       digits_ok;
    logic       load_ok;

    assign tens   = o_q[7:4];
    assign units  = o_q[3:0];
    assign at_max = (o_q == MAX_BCD);
    assign at_min = (o_q == MIN_BCD);
    assign wrap   = i_inc ? at_max : at_min;

    assign o_carry = i_ena & ~i_load & ~i_reset & wrap;

    // Valid BCD orders like its decimal value, so range checks use raw codes;
    // borrow bits avoid constant compares when MIN_VAL is 0.
    assign lo_diff   = {1'b0, i_load_val} - {1'b0, MIN_BCD};
    assign hi_diff   = {1'b0, MAX_BCD} - {1'b0, i_load_val};
    assign digits_ok = (i_load_val[7:4] <= 4'd9) && (i_load_val[3:0] <= 4'd9);
    assign load_ok   = digits_ok && !lo_diff[8] && !hi_diff[8];

    always_comb begin
        q_step = o_q;
        if (i_inc) begin
            if (at_max) begin
                q_step = MIN_BCD;
            end else if (units == 4'd9) begin
                q_step = {tens + 4'd1, 4'd0};
            end else begin
                q_step = {tens, units + 4'd1};
            end
        end else begin
            if (at_min) begin
                q_step = MAX_BCD;
            end else if (units == 4'd0) begin
                q_step = {tens - 4'd1, 4'd9};
            end else begin
                q_step = {tens, units - 4'd1};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_q        <= MIN_BCD;
            o_roll     <= 1'b0;
            o_load_err <= 1'b0;
        end else begin
            o_roll     <= 1'b0;
            o_load_err <= 1'b0;
            if (i_load) begin
                if (load_ok) begin
                    o_q <= i_load_val;
                end else begin
                    o_load_err <= 1'b1;
                end
            end else if (i_ena) begin
                o_q    <= q_step;
                o_roll <= wrap;
            end
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: 0-59, 1-12, 0-23 and a two-stage
// cascade, each scenario in its own task.
module tb_bcd_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // default 0-59 instance
    logic       rst_a = 1'b0, ena_a = 1'b0, inc_a = 1'b1, load_a = 1'b0;
    logic [7:0] lval_a = 8'h00, q_a;
    logic       carry_a, roll_a, err_a;

    // 1-12 instance
    logic       rst_b = 1'b0, ena_b = 1'b0, inc_b = 1'b1, load_b = 1'b0;
    logic [7:0] lval_b = 8'h00, q_b;
    logic       carry_b, roll_b, err_b;

    // 0-23 instance
    logic       rst_h = 1'b0, ena_h = 1'b0, inc_h = 1'b1, load_h = 1'b0;
    logic [7:0] lval_h = 8'h00, q_h;
    logic       carry_h, roll_h, err_h;

    // cascade: stage 1 is enabled by stage 0 carry
    logic       rst_c = 1'b0, ena_c = 1'b0, inc_c = 1'b1;
    logic       load_c0 = 1'b0, load_c1 = 1'b0;
    logic [7:0] lval_c0 = 8'h00, lval_c1 = 8'h00, q_c0, q_c1;
    logic       carry_c0, carry_c1, roll_c0, roll_c1, err_c0, err_c1;

    bcd_mod_counter u_a (
        .i_clk(clk), .i_reset(rst_a), .i_ena(ena_a), .i_inc(inc_a),
        .i_load(load_a), .i_load_val(lval_a), .o_q(q_a),
        .o_carry(carry_a), .o_roll(roll_a), .o_load_err(err_a)
    );

    bcd_mod_counter #(.MIN_VAL(1), .MAX_VAL(12)) u_b (
        .i_clk(clk), .i_reset(rst_b), .i_ena(ena_b), .i_inc(inc_b),
        .i_load(load_b), .i_load_val(lval_b), .o_q(q_b),
        .o_carry(carry_b), .o_roll(roll_b), .o_load_err(err_b)
    );

    bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(23)) u_h (
        .i_clk(clk), .i_reset(rst_h), .i_ena(ena_h), .i_inc(inc_h),
        .i_load(load_h), .i_load_val(lval_h), .o_q(q_h),
        .o_carry(carry_h), .o_roll(roll_h), .o_load_err(err_h)
    );

    bcd_mod_counter u_c0 (
        .i_clk(clk), .i_reset(rst_c), .i_ena(ena_c), .i_inc(inc_c),
        .i_load(load_c0), .i_load_val(lval_c0), .o_q(q_c0),
        .o_carry(carry_c0), .o_roll(roll_c0), .o_load_err(err_c0)
    );

    bcd_mod_counter u_c1 (
        .i_clk(clk), .i_reset(rst_c), .i_ena(carry_c0), .i_inc(inc_c),
        .i_load(load_c1), .i_load_val(lval_c1), .o_q(q_c1),
        .o_carry(carry_c1), .o_roll(roll_c1), .o_load_err(err_c1)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_h = 1'b1; rst_c = 1'b1;
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_h = 1'b0; rst_c = 1'b0;
        vectors++; if (q_a !== 8'h00) begin miscompares++; $display("FAIL reset_q_a got %h want 00", q_a); end
        vectors++; if (roll_a !== 1'b0) begin miscompares++; $display("FAIL reset_roll_a got %b want 0", roll_a); end
        vectors++; if (err_a !== 1'b0) begin miscompares++; $display("FAIL reset_err_a got %b want 0", err_a); end
        vectors++; if (q_b !== 8'h01) begin miscompares++; $display("FAIL reset_q_b got %h want 01", q_b); end
    endtask

    task automatic test_count_up();
        ena_a = 1'b1; inc_a = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            #1;
            vectors++;
            if (carry_a !== (i == 60)) begin
                miscompares++;
                $display("FAIL up_carry edge %0d got %b want %b", i, carry_a, (i == 60));
            end
            tick();
            vectors++;
            if (q_a !== to_bcd(i % 60)) begin
                miscompares++;
                $display("FAIL up_q edge %0d got %h want %h", i, q_a, to_bcd(i % 60));
            end
            vectors++;
            if (roll_a !== (i == 60)) begin
                miscompares++;
                $display("FAIL up_roll edge %0d got %b want %b", i, roll_a, (i == 60));
            end
        end
        ena_a = 1'b0;
        tick();
        vectors++; if (roll_a !== 1'b0) begin miscompares++; $display("FAIL up_roll_drop got %b want 0", roll_a); end
        vectors++; if (q_a !== 8'h00) begin miscompares++; $display("FAIL up_hold got %h want 00", q_a); end
    endtask

    task automatic test_hours_12();
        ena_b = 1'b1; inc_b = 1'b0;
        #1;
        vectors++; if (carry_b !== 1'b1) begin miscompares++; $display("FAIL h12_carry_down got %b want 1", carry_b); end
        tick();
        vectors++; if (q_b !== 8'h12) begin miscompares++; $display("FAIL h12_down_q got %h want 12", q_b); end
        vectors++; if (roll_b !== 1'b1) begin miscompares++; $display("FAIL h12_down_roll got %b want 1", roll_b); end
        ena_b = 1'b0; load_b = 1'b1; lval_b = 8'h09;
        tick();
        load_b = 1'b0; ena_b = 1'b1; inc_b = 1'b1;
        tick();
        vectors++; if (q_b !== 8'h10) begin miscompares++; $display("FAIL h12_up9_q got %h want 10", q_b); end
        vectors++; if (roll_b !== 1'b0) begin miscompares++; $display("FAIL h12_up9_roll got %b want 0", roll_b); end
        tick();
        tick();
        vectors++; if (q_b !== 8'h12) begin miscompares++; $display("FAIL h12_up12_q got %h want 12", q_b); end
        vectors++; if (carry_b !== 1'b1) begin miscompares++; $display("FAIL h12_carry_up got %b want 1", carry_b); end
        tick();
        vectors++; if (q_b !== 8'h01) begin miscompares++; $display("FAIL h12_wrap_q got %h want 01", q_b); end
        vectors++; if (roll_b !== 1'b1) begin miscompares++; $display("FAIL h12_wrap_roll got %b want 1", roll_b); end
        ena_b = 1'b0;
        tick();
        vectors++; if (roll_b !== 1'b0) begin miscompares++; $display("FAIL h12_roll_drop got %b want 0", roll_b); end
        load_b = 1'b1; lval_b = 8'h00;
        tick();
        load_b = 1'b0;
        vectors++; if (err_b !== 1'b1) begin miscompares++; $display("FAIL h12_load00_err got %b want 1", err_b); end
        vectors++; if (q_b !== 8'h01) begin miscompares++; $display("FAIL h12_load00_q got %h want 01", q_b); end
    endtask

    task automatic test_load();
        load_a = 1'b1; lval_a = 8'h45; ena_a = 1'b0;
        tick();
        vectors++; if (q_a !== 8'h45) begin miscompares++; $display("FAIL load45_q got %h want 45", q_a); end
        vectors++; if (err_a !== 1'b0) begin miscompares++; $display("FAIL load45_err got %b want 0", err_a); end
        lval_a = 8'h7A;
        tick();
        vectors++; if (q_a !== 8'h45) begin miscompares++; $display("FAIL load7A_q got %h want 45", q_a); end
        vectors++; if (err_a !== 1'b1) begin miscompares++; $display("FAIL load7A_err got %b want 1", err_a); end
        load_a = 1'b0;
        tick();
        vectors++; if (err_a !== 1'b0) begin miscompares++; $display("FAIL load_err_drop got %b want 0", err_a); end
        load_a = 1'b1; lval_a = 8'h30; ena_a = 1'b1; inc_a = 1'b1;
        tick();
        vectors++; if (q_a !== 8'h30) begin miscompares++; $display("FAIL load30_ena_q got %h want 30", q_a); end
        vectors++; if (err_a !== 1'b0) begin miscompares++; $display("FAIL load30_ena_err got %b want 0", err_a); end
        lval_a = 8'h60;
        tick();
        vectors++; if (q_a !== 8'h30) begin miscompares++; $display("FAIL load60_ena_q got %h want 30", q_a); end
        vectors++; if (err_a !== 1'b1) begin miscompares++; $display("FAIL load60_ena_err got %b want 1", err_a); end
        ena_a = 1'b0; lval_a = 8'h59;
        tick();
        ena_a = 1'b1; lval_a = 8'h12;
        #1;
        vectors++; if (carry_a !== 1'b0) begin miscompares++; $display("FAIL load_carry_mask got %b want 0", carry_a); end
        tick();
        vectors++; if (q_a !== 8'h12) begin miscompares++; $display("FAIL load12_q got %h want 12", q_a); end
        vectors++; if (roll_a !== 1'b0) begin miscompares++; $display("FAIL load12_roll got %b want 0", roll_a); end
        load_a = 1'b0; ena_a = 1'b0;
    endtask

    task automatic test_hours_24();
        load_h = 1'b1; lval_h = 8'h24;
        tick();
        vectors++; if (err_h !== 1'b1) begin miscompares++; $display("FAIL h24_load24_err got %b want 1", err_h); end
        vectors++; if (q_h !== 8'h00) begin miscompares++; $display("FAIL h24_load24_q got %h want 00", q_h); end
        lval_h = 8'h23;
        tick();
        load_h = 1'b0; ena_h = 1'b1; inc_h = 1'b1;
        vectors++; if (q_h !== 8'h23) begin miscompares++; $display("FAIL h24_load23_q got %h want 23", q_h); end
        vectors++; if (err_h !== 1'b0) begin miscompares++; $display("FAIL h24_load23_err got %b want 0", err_h); end
        tick();
        ena_h = 1'b0;
        vectors++; if (q_h !== 8'h00) begin miscompares++; $display("FAIL h24_wrap_q got %h want 00", q_h); end
        vectors++; if (roll_h !== 1'b1) begin miscompares++; $display("FAIL h24_wrap_roll got %b want 1", roll_h); end
    endtask

    task automatic test_cascade();
        load_c0 = 1'b1; lval_c0 = 8'h59; load_c1 = 1'b1; lval_c1 = 8'h59;
        tick();
        load_c0 = 1'b0; load_c1 = 1'b0; ena_c = 1'b1; inc_c = 1'b1;
        #1;
        vectors++; if (carry_c1 !== 1'b1) begin miscompares++; $display("FAIL casc_up_carry1 got %b want 1", carry_c1); end
        tick();
        ena_c = 1'b0;
        vectors++; if ({q_c1, q_c0} !== 16'h0000) begin miscompares++; $display("FAIL casc_up_q got %h want 0000", {q_c1, q_c0}); end
        vectors++; if ({roll_c1, roll_c0} !== 2'b11) begin miscompares++; $display("FAIL casc_up_roll got %b want 11", {roll_c1, roll_c0}); end
        tick();
        vectors++; if ({roll_c1, roll_c0} !== 2'b00) begin miscompares++; $display("FAIL casc_roll_drop got %b want 00", {roll_c1, roll_c0}); end
        ena_c = 1'b1; inc_c = 1'b0;
        tick();
        ena_c = 1'b0;
        vectors++; if ({q_c1, q_c0} !== 16'h5959) begin miscompares++; $display("FAIL casc_dn_q got %h want 5959", {q_c1, q_c0}); end
        vectors++; if ({roll_c1, roll_c0} !== 2'b11) begin miscompares++; $display("FAIL casc_dn_roll got %b want 11", {roll_c1, roll_c0}); end
        ena_c = 1'b1;
        tick();
        ena_c = 1'b0;
        vectors++; if ({q_c1, q_c0} !== 16'h5958) begin miscompares++; $display("FAIL casc_dn2_q got %h want 5958", {q_c1, q_c0}); end
        vectors++; if ({roll_c1, roll_c0} !== 2'b00) begin miscompares++; $display("FAIL casc_dn2_roll got %b want 00", {roll_c1, roll_c0}); end
    endtask

    task automatic test_reset_at_wrap();
        load_a = 1'b1; lval_a = 8'h58;
        tick();
        load_a = 1'b0; ena_a = 1'b1; inc_a = 1'b1;
        tick();
        vectors++; if (q_a !== 8'h59) begin miscompares++; $display("FAIL rw_q59 got %h want 59", q_a); end
        rst_a = 1'b1;
        #1;
        vectors++; if (carry_a !== 1'b0) begin miscompares++; $display("FAIL rw_carry_mask got %b want 0", carry_a); end
        tick();
        rst_a = 1'b0; ena_a = 1'b0;
        vectors++; if (q_a !== 8'h00) begin miscompares++; $display("FAIL rw_q got %h want 00", q_a); end
        vectors++; if (roll_a !== 1'b0) begin miscompares++; $display("FAIL rw_roll got %b want 0", roll_a); end
        tick();
        vectors++; if (roll_a !== 1'b0) begin miscompares++; $display("FAIL rw_roll_after got %b want 0", roll_a); end
    endtask

    task automatic test_hold();
        ena_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            inc_a = i[0];
            #1;
            vectors++;
            if (carry_a !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_carry cyc %0d got %b want 0", i, carry_a);
            end
            tick();
            vectors++;
            if (q_a !== 8'h00) begin
                miscompares++;
                $display("FAIL hold_q cyc %0d got %h want 00", i, q_a);
            end
            vectors++;
            if (roll_a !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_roll cyc %0d got %b want 0", i, roll_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_hours_12();
        test_load();
        test_hours_24();
        test_cascade();
        test_reset_at_wrap();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
